// File: rtl/cache_pkg.sv
// cache_pkg: FSM encoding and default cache geometry shared by the cache blocks.
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_CACHE_SIZE = 512;
  localparam int DEF_BLOCK_SIZE = 32;
  localparam int DEF_NUM_WAYS = 4;
  function automatic int num_sets(input int cache_size, input int block_size, input int ways);
    return cache_size / (block_size * ways);
  endfunction
  localparam int DEF_NUM_SETS = num_sets(DEF_CACHE_SIZE, DEF_BLOCK_SIZE, DEF_NUM_WAYS);
  localparam int DEF_OFFSET_W = $clog2(DEF_BLOCK_SIZE);
  localparam int DEF_INDEX_W = $clog2(DEF_NUM_SETS);
  localparam int DEF_TAG_W = DEF_ADDR_WIDTH - DEF_OFFSET_W - DEF_INDEX_W;
endpackage

// File: rtl/cache_lru_age.sv
// cache_lru_age: next per-way ages of one set after touching way_i (touched way becomes youngest).
module cache_lru_age #(
  parameter int NUM_WAYS = 4,
  parameter int AW = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][AW-1:0] age_i,
  input  logic [AW-1:0]               way_i,
  output logic [NUM_WAYS-1:0][AW-1:0] age_o
);
  always_comb begin
    age_o = age_i;
    for (int w = 0; w < NUM_WAYS; w++)
      age_o[w] = (AW'(w) == way_i) ? '0 :
                 (age_i[w] < age_i[way_i]) ? age_i[w] + AW'(1) : age_i[w];
  end
endmodule

// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb: blocking write-back set-associative cache, one word per line, LRU replacement,
// with saturating hit/miss statistics.
module cache_assoc_wb
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  parameter int CACHE_SIZE = DEF_CACHE_SIZE,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
  parameter int NUM_WAYS = DEF_NUM_WAYS,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  output logic                   resp_hit,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ack,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);
  localparam int NUM_SETS = num_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
  localparam int OW = $clog2(BLOCK_SIZE);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = ADDR_WIDTH - OW - IW;
  localparam int AW = $clog2(NUM_WAYS);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-OW-1:0] blk_q;
  logic write_q, hit_q, resp_valid_q, resp_hit_q;
  logic [DATA_WIDTH-1:0] wdata_q, resp_rdata_q;
  logic [COUNT_WIDTH-1:0] hit_count_q, miss_count_q;
  logic [AW-1:0] victim_q, victim, hit_way, acc_way;
  logic hit;
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
  logic [NUM_WAYS-1:0][AW-1:0] age_q [NUM_SETS];
  logic [NUM_WAYS-1:0][AW-1:0] age_next;
  logic [TW-1:0] tag_q [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0] data_q [NUM_SETS][NUM_WAYS];
  logic [IW-1:0] idx;
  logic [TW-1:0] tg;
  assign idx = blk_q[IW-1:0];
  assign tg = blk_q[ADDR_WIDTH-OW-1 -: TW];
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (valid_q[idx][w] && tag_q[idx][w] == tg) begin
        hit = 1'b1;
        hit_way = AW'(w);
      end
  end
  // Oldest way is the fallback; any invalid way wins, lowest index last so it takes priority.
  always_comb begin
    victim = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (age_q[idx][w] == AW'(NUM_WAYS - 1)) victim = AW'(w);
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim = AW'(w);
  end
  assign acc_way = (state_q == REFILL) ? victim_q : hit_way;
  cache_lru_age #(.NUM_WAYS(NUM_WAYS), .AW(AW)) u_age (
    .age_i (age_q[idx]),
    .way_i (acc_way),
    .age_o (age_next)
  );
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = req_valid ? LOOKUP : IDLE;
      LOOKUP:    state_d = hit ? RESPOND :
                           (valid_q[idx][victim] && dirty_q[idx][victim]) ? WRITEBACK : REFILL;
      WRITEBACK: state_d = mem_ack ? REFILL : WRITEBACK;
      REFILL:    state_d = mem_ack ? RESPOND : REFILL;
      RESPOND:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      resp_valid_q <= 1'b0;
      resp_hit_q <= 1'b0;
      resp_rdata_q <= '0;
      hit_count_q <= '0;
      miss_count_q <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) age_q[s][w] <= AW'(w);
      end
    end else begin
      state_q <= state_d;
      resp_valid_q <= state_q == RESPOND;
      resp_hit_q <= state_q == RESPOND && hit_q;
      if (state_q == IDLE && req_valid) begin
        blk_q <= req_addr[ADDR_WIDTH-1:OW];
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      if (state_q == LOOKUP) begin
        hit_q <= hit;
        victim_q <= victim;
        if (hit) begin
          age_q[idx] <= age_next;
          resp_rdata_q <= write_q ? wdata_q : data_q[idx][hit_way];
          if (write_q) begin
            data_q[idx][hit_way] <= wdata_q;
            dirty_q[idx][hit_way] <= 1'b1;
          end
        end else if (!(&miss_count_q)) miss_count_q <= miss_count_q + COUNT_WIDTH'(1);
      end
      if (state_q == REFILL && mem_ack) begin
        tag_q[idx][victim_q] <= tg;
        data_q[idx][victim_q] <= write_q ? wdata_q : mem_rdata;
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= write_q;
        age_q[idx] <= age_next;
        resp_rdata_q <= write_q ? wdata_q : mem_rdata;
      end
      if (state_q == RESPOND && hit_q && !(&hit_count_q)) hit_count_q <= hit_count_q + COUNT_WIDTH'(1);
    end
  end
  assign req_ready = state_q == IDLE && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_hit = resp_hit_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req = state_q == WRITEBACK || state_q == REFILL;
  assign mem_we = state_q == WRITEBACK;
  assign mem_addr = (state_q == WRITEBACK) ? {tag_q[idx][victim_q], idx, {OW{1'b0}}} :
                    (state_q == REFILL) ? {tg, idx, {OW{1'b0}}} : '0;
  assign mem_wdata = (state_q == WRITEBACK) ? data_q[idx][victim_q] : '0;
  assign hit_count = hit_count_q;
  assign miss_count = miss_count_q;
endmodule

// File: doc/cache_assoc_wb.md
CACHE_ASSOC_WB -- requirements
Module: cache_assoc_wb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11: byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: word width; one word per line.
REQ-003 SHALL have parameter CACHE_SIZE, default 512, and parameter BLOCK_SIZE, default 32: capacity and line size in bytes.
REQ-004 SHALL have parameter NUM_WAYS, default 4: associativity, a power of two ≥2.
REQ-005 SHALL have parameter COUNT_WIDTH, default 16: width of the statistics counters.
REQ-006 SHALL derive NUM_SETS = CACHE_SIZE/(BLOCK_SIZE*NUM_WAYS), OFFSET = clog2(BLOCK_SIZE) LSBs, INDEX = next clog2(NUM_SETS) bits, TAG = remaining MSBs.
REQ-007 SHALL have ports as follows, one per line; one clock; reset is synchronous and active-high.
 clk  in  1  clock, all state changes on rising edge
 rst  in  1  synchronous active-high reset
 req_valid  in  1  request present
 req_ready  out  1  block can accept a request
 req_write  in  1  1=write, 0=read
 req_addr  in  ADDR_WIDTH  request address
 req_wdata  in  DATA_WIDTH  write data
 resp_valid  out  1  one-cycle response strobe
 resp_hit  out  1  request hit (qualified by resp_valid)
 resp_rdata  out  DATA_WIDTH  read data, or write data on writes
 mem_req  out  1  next-level request
 mem_we  out  1  1=write-back, 0=refill
 mem_addr  out  ADDR_WIDTH  line address, offset bits zero
 mem_wdata  out  DATA_WIDTH  victim data
 mem_ack  in  1  next-level completion; mem_rdata valid this cycle
 mem_rdata  in  DATA_WIDTH  refill data
 hit_count  out  COUNT_WIDTH  saturating hit counter
 miss_count  out  COUNT_WIDTH  saturating miss counter

Function
REQ-008 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
REQ-009 SHALL assert req_ready only in IDLE with rst low; the request is captured on a cycle where req_valid&&req_ready, then the FSM goes to LOOKUP.
REQ-010 LOOKUP SHALL compare the tag against all valid ways of the indexed set; on a hit go to RESPOND; on a miss increment miss_count and go to WRITEBACK if the victim is valid and dirty, else to REFILL.
REQ-011 Hit latency SHALL be 2 cycles: resp_valid is high for exactly one cycle, 2 cycles after the acceptance edge; hit_count increments on that response.
REQ-012 Victim selection SHALL pick the lowest-index invalid way, else the way whose age equals NUM_WAYS-1.
REQ-013 LRU SHALL use per-way ages (clog2(NUM_WAYS) bits) forming a permutation per set; on a hit or fill, the accessed way is set to 0 and ways with a smaller age increment by 1.
REQ-014 WRITEBACK SHALL hold mem_req=1, mem_we=1, mem_addr={victim tag,index,0} and mem_wdata=victim data stable until mem_ack, then go to REFILL.
REQ-015 REFILL SHALL hold mem_req=1, mem_we=0, mem_addr={tag,index,0} until mem_ack; on the ack cycle it installs tag and mem_rdata, sets valid, clears dirty, and goes to RESPOND with resp_hit=0.
REQ-016 Write hit or write-after-refill SHALL store req_wdata in the line, set dirty, and return req_wdata on resp_rdata.
REQ-017 mem_req SHALL drop in the cycle after mem_ack; mem_ack outside WRITEBACK/REFILL SHALL be ignored.
REQ-018 Counters SHALL saturate at all-ones.

Reset
REQ-019 On rst: FSM=IDLE, all valid and dirty cleared, age of way w = w in every set, hit_count=miss_count=0, resp_valid=resp_hit=mem_req=mem_we=0, resp_rdata=mem_addr=mem_wdata=0.
REQ-020 rst mid-transaction SHALL abandon it: no response, and mem_req is low from the cycle after rst is sampled.

Structure
REQ-021 A shared package cache_pkg SHALL hold the FSM state encodings and the derived geometry constants.
REQ-022 Age update SHALL be a sub-module cache_lru_age (inputs: current ages, accessed way; output: next ages), instantiated once.

Verification
REQ-023 After reset, read 0x000 with mem_ack 3 cycles after mem_req and mem_rdata=0xCAFEF00D -> mem_addr=0x000, mem_we=0, resp_hit=0, rdata=0xCAFEF00D; repeat the read -> resp_hit=1, 2-cycle latency, no mem_req.
REQ-024 Fill set 0 with reads of 0x000, 0x080, 0x100, 0x180, re-read 0x000, then read 0x200 -> the way holding 0x080 is evicted with no WRITEBACK; a following read of 0x000 hits.
REQ-025 Write 0x12345678 to 0x080 (hit), then force its eviction -> WRITEBACK with mem_we=1, mem_addr=0x080, mem_wdata=0x12345678 precedes the REFILL.
REQ-026 Assert rst while REFILL awaits mem_ack -> mem_req=0 next cycle, counters=0, no resp_valid; a re-read of the earlier address misses.
REQ-027 With COUNT_WIDTH=4, issue 20 hits -> hit_count=15; mem_ack pulsed in IDLE -> no state change.
